// File: rtl/pong_game_fsm.sv
// Pong game sequencer: idle / serve / play / win screens, score keeping,
// ball re-centre pulses and serve direction. All outputs are registered.
module pong_game_fsm #(
    parameter int WIN_SCORE      = 5,
    parameter int SERVE_DELAY_MS = 1000,
    parameter int WIN_HOLD_MS    = 3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1ms,
    input  logic       btn_start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [1:0] game_state,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic       serve_dir
);

    localparam logic [3:0]  WIN_S     = 4'(WIN_SCORE);
    localparam logic [11:0] SERVE_CNT = 12'(SERVE_DELAY_MS);
    localparam logic [11:0] WIN_CNT   = 12'(WIN_HOLD_MS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        WIN1  = 3'd3,
        WIN2  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        btn_prev_q, btn_prev_d;
    logic [3:0]  score1_q, score1_d;
    logic [3:0]  score2_q, score2_d;
    logic        serve_dir_q, serve_dir_d;
    logic        ball_reset_q, ball_reset_d;
    logic        ball_enable_q, ball_enable_d;
    logic [1:0]  game_state_q, game_state_d;

    logic        start_edge;
    logic [3:0]  score1_inc;
    logic [3:0]  score2_inc;

    // Saturating increments: a score never passes WIN_SCORE and never wraps.
    always_comb begin
        start_edge = btn_start & ~btn_prev_q;
        score1_inc = (score1_q >= WIN_S) ? score1_q : score1_q + 4'd1;
        score2_inc = (score2_q >= WIN_S) ? score2_q : score2_q + 4'd1;
    end

    // Next-state, counter, score and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        btn_prev_d   = btn_start;
        score1_d     = score1_q;
        score2_d     = score2_q;
        serve_dir_d  = serve_dir_q;
        ball_reset_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    score1_d     = '0;
                    score2_d     = '0;
                    serve_dir_d  = 1'b1;
                    ball_reset_d = 1'b1;
                    cnt_d        = SERVE_CNT;
                    state_d      = SERVE;
                end
            end
            SERVE: begin
                if (clk_1ms) begin
                    if (cnt_q == 12'd1) begin
                        cnt_d   = '0;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q - 12'd1;
                    end
                end
            end
            PLAY: begin
                if (miss_left && miss_right) begin
                    ball_reset_d = 1'b1;
                    cnt_d        = SERVE_CNT;
                    state_d      = SERVE;
                end else if (miss_left) begin
                    score2_d    = score2_inc;
                    serve_dir_d = 1'b0;
                    if (score2_inc == WIN_S) begin
                        cnt_d   = WIN_CNT;
                        state_d = WIN2;
                    end else begin
                        ball_reset_d = 1'b1;
                        cnt_d        = SERVE_CNT;
                        state_d      = SERVE;
                    end
                end else if (miss_right) begin
                    score1_d    = score1_inc;
                    serve_dir_d = 1'b1;
                    if (score1_inc == WIN_S) begin
                        cnt_d   = WIN_CNT;
                        state_d = WIN1;
                    end else begin
                        ball_reset_d = 1'b1;
                        cnt_d        = SERVE_CNT;
                        state_d      = SERVE;
                    end
                end
            end
            WIN1, WIN2: begin
                if (clk_1ms) begin
                    if (cnt_q == 12'd1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 12'd1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Renderer outputs are derived from the next state so they register
        // in step with the state itself.
        case (state_d)
            SERVE, PLAY: game_state_d = 2'b01;
            WIN1:        game_state_d = 2'b10;
            WIN2:        game_state_d = 2'b11;
            default:     game_state_d = 2'b00;
        endcase
        ball_enable_d = (state_d == PLAY);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            btn_prev_q    <= 1'b1;
            score1_q      <= '0;
            score2_q      <= '0;
            serve_dir_q   <= 1'b1;
            ball_reset_q  <= 1'b0;
            ball_enable_q <= 1'b0;
            game_state_q  <= 2'b00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            btn_prev_q    <= btn_prev_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            serve_dir_q   <= serve_dir_d;
            ball_reset_q  <= ball_reset_d;
            ball_enable_q <= ball_enable_d;
            game_state_q  <= game_state_d;
        end
    end

    assign game_state  = game_state_q;
    assign score1      = score1_q;
    assign score2      = score2_q;
    assign ball_enable = ball_enable_q;
    assign ball_reset  = ball_reset_q;
    assign serve_dir   = serve_dir_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Directed self-checking bench for pong_game_fsm with small delays.
module tb_pong_game_fsm;

    logic       clk;
    logic       reset;
    logic       clk_1ms;
    logic       btn_start;
    logic       miss_left;
    logic       miss_right;
    logic [1:0] game_state;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       ball_enable;
    logic       ball_reset;
    logic       serve_dir;

    int total = 0;
    int bad   = 0;

    pong_game_fsm #(
        .WIN_SCORE      (2),
        .SERVE_DELAY_MS (3),
        .WIN_HOLD_MS    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_1ms     (clk_1ms),
        .btn_start   (btn_start),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .game_state  (game_state),
        .score1      (score1),
        .score2      (score2),
        .ball_enable (ball_enable),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One compare: counts, and reports any difference.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        clk_1ms = 1'b1;
        step();
        clk_1ms = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] gs, input logic [3:0] s1,
                           input logic [3:0] s2, input logic be, input logic br, input logic sd);
        chk({tag, ".game_state"},  8'(game_state),  8'(gs));
        chk({tag, ".score1"},      8'(score1),      8'(s1));
        chk({tag, ".score2"},      8'(score2),      8'(s2));
        chk({tag, ".ball_enable"}, 8'(ball_enable), 8'(be));
        chk({tag, ".ball_reset"},  8'(ball_reset),  8'(br));
        chk({tag, ".serve_dir"},   8'(serve_dir),   8'(sd));
    endtask

    initial begin
        reset      = 1'b0;
        clk_1ms    = 1'b0;
        btn_start  = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        #12;
        chk_all("reset", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b1;
        step();
        step();
        chk_all("idle", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        // Start: ball_reset one cycle, serve lasts exactly 3 strobes.
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        chk_all("start", 2'b01, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk("start.br_end", 8'(ball_reset), 8'd0);
        strobe();
        chk("serve.s1", 8'(ball_enable), 8'd0);
        step();
        strobe();
        chk("serve.s2", 8'(ball_enable), 8'd0);
        strobe();
        chk_all("play", 2'b01, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);

        // Right miss scores player 1.
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        chk_all("miss_r", 2'b01, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk("miss_r.br_end", 8'(ball_reset), 8'd0);
        // Miss during SERVE is ignored.
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        chk("serve_ign.score2", 8'(score2), 8'd0);
        strobe(); strobe(); strobe();
        chk("play2.be", 8'(ball_enable), 8'd1);

        // Start edge during PLAY has no effect.
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        chk_all("btn_in_play", 2'b01, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1);

        // Left miss scores player 2 and serves left.
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        chk_all("miss_l", 2'b01, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
        strobe(); strobe(); strobe();
        chk("play3.be", 8'(ball_enable), 8'd1);

        // Simultaneous misses: no point, direction kept, re-serve.
        miss_left  = 1'b1;
        miss_right = 1'b1;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        chk_all("both", 2'b01, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
        step();
        chk("both.br_end", 8'(ball_reset), 8'd0);
        strobe(); strobe(); strobe();
        chk("play4.be", 8'(ball_enable), 8'd1);

        // Asynchronous reset mid-PLAY with start held across release.
        btn_start = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b1;
        step();
        step();
        chk_all("held_btn", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        chk_all("restart", 2'b01, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

        // Player 1 wins; strobe on the entry cycle must not count.
        strobe(); strobe(); strobe();
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        chk("w1.score1", 8'(score1), 8'd1);
        strobe(); strobe(); strobe();
        miss_right = 1'b1;
        clk_1ms    = 1'b1;
        step();
        miss_right = 1'b0;
        clk_1ms    = 1'b0;
        chk_all("win1", 2'b10, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        strobe(); strobe(); strobe();
        chk("win1.hold3", 8'(game_state), 8'd2);
        strobe();
        chk_all("win1.done", 2'b00, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1);

        // Player 2 wins; misses in WIN2 are ignored.
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        chk_all("game2", 2'b01, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        strobe(); strobe(); strobe();
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        strobe(); strobe(); strobe();
        miss_left = 1'b1;
        step();
        miss_left = 1'b0;
        chk_all("win2", 2'b11, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        miss_left = 1'b1;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        chk_all("win2_ign", 2'b11, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        strobe(); strobe(); strobe(); strobe();
        chk_all("win2.done", 2'b00, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
